// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low hex segment table,
// blank pattern and segment bit positions (bit 6 = a ... bit 0 = g).
package seven_seg_pkg;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Entry n is the segment pattern for nibble n; listed from F down to 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex seven-segment scanner with per-frame shadow capture and a
// ghosting guard at each digit change. Define SEVSEG_LZ_BLANK_EN for leading-zero blanking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic [NUM_DIGITS-1:0]     dp,
  output logic [6:0]                seg,
  output logic                      dp_n,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic                      frame_done
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   value_sh;
  logic [NUM_DIGITS-1:0]     blank_sh;
  logic [NUM_DIGITS-1:0]     dp_sh;

  logic [NUM_DIGITS-1:0]     lz_blank;
  logic [NUM_DIGITS-1:0]     eff_blank;
  logic [NUM_DIGITS-1:0]     sel_n;
  logic [3:0]                cur_nib;
  logic                      cur_blank;
  logic                      cur_dp;
  logic                      cnt_last;
  logic                      idx_last;
  logic                      in_guard;
  logic [6:0]                dec_seg;

`ifdef SEVSEG_LZ_BLANK_EN
  logic lz_run;

  // Walk from the most significant digit down; a digit is suppressed while every
  // nibble from it upward is zero. Digit 0 always shows.
  always_comb begin
    lz_run   = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run      = lz_run & (value_sh[i*4 +: 4] == 4'h0);
      lz_blank[i] = (i != 0) && lz_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign eff_blank = blank_sh | lz_blank;

  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b1;
    cur_dp    = 1'b0;
    sel_n     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = value_sh[i*4 +: 4];
        cur_blank = eff_blank[i];
        cur_dp    = dp_sh[i];
        sel_n[i]  = 1'b0;
      end
    end
  end

  assign cnt_last = (cnt == CW'(REFRESH_DIV - 1));
  assign idx_last = (idx == IW'(NUM_DIGITS - 1));
  assign in_guard = (cnt < CW'(GUARD_CYCLES));

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      value_sh   <= '0;
      blank_sh   <= '0;
      dp_sh      <= '0;
      seg        <= SEG_OFF;
      dp_n       <= 1'b1;
      anode      <= '1;
      frame_done <= 1'b0;
    end else if (!enable) begin
      // Dark and tracking inputs, so re-enable starts at digit 0 with fresh data.
      cnt        <= '0;
      idx        <= '0;
      value_sh   <= value;
      blank_sh   <= blank;
      dp_sh      <= dp;
      seg        <= SEG_OFF;
      dp_n       <= 1'b1;
      anode      <= '1;
      frame_done <= 1'b0;
    end else begin
      // Segments follow the new digit immediately; the anode waits out the guard.
      seg        <= cur_blank ? SEG_OFF : dec_seg;
      dp_n       <= cur_blank | ~cur_dp;
      anode      <= (cur_blank | in_guard) ? '1 : sel_n;
      frame_done <= cnt_last & idx_last;
      if (cnt_last) begin
        cnt <= '0;
        if (idx_last) begin
          idx      <= '0;
          value_sh <= value;
          blank_sh <= blank;
          dp_sh    <= dp;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: directed test-plan phases then random stimulus.
module tb_seven_seg_scan;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int G  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  anode;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .value      (value),
    .blank      (blank),
    .dp         (dp),
    .seg        (seg),
    .dp_n       (dp_n),
    .anode      (anode),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp_n;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  logic [6:0] hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference state: cycles elapsed in the current scan and the captured frame data.
  int          t = 0;
  logic [15:0] m_val   = '0;
  logic [3:0]  m_blank = '0;
  logic [3:0]  m_dp    = '0;

  function automatic logic lz_sup(input int d);
`ifdef SEVSEG_LZ_BLANK_EN
    if (d == 0) return 1'b0;
    for (int k = d; k < N; k++) if (m_val[k*4 +: 4] != 4'h0) return 1'b0;
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  // Predict the outputs produced by the coming clock edge, then advance the model.
  task automatic step();
    exp_t e;
    int   slot;
    int   off;
    logic bl;
    e = '{anode: 4'hF, seg: 7'h7F, dp_n: 1'b1, fd: 1'b0};
    if (reset) begin
      t = 0; m_val = '0; m_blank = '0; m_dp = '0;
    end else if (!enable) begin
      t = 0; m_val = value; m_blank = blank; m_dp = dp;
    end else begin
      slot = (t / RD) % N;
      off  = t % RD;
      bl   = m_blank[slot] | lz_sup(slot);
      if (!bl) begin
        e.seg  = hex_tab[m_val[slot*4 +: 4]];
        e.dp_n = ~m_dp[slot];
        if (off >= G) e.anode = ~(4'b0001 << slot);
      end
      e.fd = (t == N * RD - 1);
      if (e.fd) begin
        m_val = value; m_blank = blank; m_dp = dp;
      end
      t = (t + 1) % (N * RD);
    end
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      step();
      @(negedge clk);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare each against the queue head.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = '{anode: anode, seg: seg, dp_n: dp_n, fd: frame_done};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL outputs @%0t: got anode=%b seg=%b dp_n=%b fd=%b, want anode=%b seg=%b dp_n=%b fd=%b",
                   $time, got.anode, got.seg, got.dp_n, got.fd, e.anode, e.seg, e.dp_n, e.fd);
        end
        tests++;
        if ($countones(~anode) > 1) begin
          fails++;
          $display("FAIL anode_onehot @%0t: got %b, want at most one low bit", $time, anode);
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    value  = 16'h12AF;
    blank  = 4'b0000;
    dp     = 4'b0000;
    @(negedge clk);
    cyc(3);
    reset = 1'b0;
    cyc(64);
    // Mid-frame change lands in slot 1; that frame keeps the old value.
    cyc(10);
    value = 16'h3456;
    cyc(22 + 64);
    dp    = 4'b0100;
    blank = 4'b1000;
    cyc(96);
    dp    = 4'b0000;
    blank = 4'b0000;
    value = 16'h0050;
    cyc(96);
    // Abort during slot 2, then resume.
    cyc(18);
    enable = 1'b0;
    cyc(3);
    enable = 1'b1;
    cyc(48);
    repeat (1500) begin
      if ($urandom_range(0, 9) == 0) value = 16'($urandom);
      if ($urandom_range(0, 9) == 0) blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 9) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) value = {12'h000, 4'($urandom)};
      enable = ($urandom_range(0, 59) != 0);
      reset  = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(4);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed hexadecimal seven-segment display driver. It replaces the fixed 4-digit combinational display mux. It holds its own refresh divider and digit scan counter, and decodes the full 0-F hex range. It captures the displayed value once per frame so the display does not tear, and inserts a ghosting guard interval at every digit change. It sits between the ALU/top-level result registers and the board's common-anode display pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned, legal range 1..8; digit 0 is rightmost.
- `REFRESH_DIV`, 100000: clock cycles per digit slot, minimum 2.
- `GUARD_CYCLES`, 16: cycles at the start of each slot with all anodes off; must be less than `REFRESH_DIV`.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: scan enable; low turns the display dark and restarts the scan.
- `value` in 4*NUM_DIGITS: hex nibbles; nibble i drives digit i.
- `blank` in NUM_DIGITS: per-digit forced blank.
- `dp` in NUM_DIGITS: per-digit decimal point on.
- `seg` out 7: active-low segments, bit 6 = a through bit 0 = g.
- `dp_n` out 1: active-low decimal point.
- `anode` out NUM_DIGITS: active-low digit select; at most one bit low.
- `frame_done` out 1: one-cycle pulse after the last slot of each frame.

## Operation
- Slot counter `cnt` runs 0..REFRESH_DIV-1. Digit index `idx` runs 0..NUM_DIGITS-1.
- While `enable` is high, `cnt` increments every cycle. When `cnt` = REFRESH_DIV-1, `cnt` goes to 0 and `idx` advances, wrapping from NUM_DIGITS-1 to 0.
- Frame end is `cnt` = REFRESH_DIV-1 with `idx` = NUM_DIGITS-1. On that cycle:
  - the shadow registers load `value`, `blank` and `dp`;
  - `frame_done` goes high on the following cycle, for exactly one cycle.
- While `enable` is low:
  - `cnt` and `idx` are held at 0;
  - the shadow registers load `value`, `blank` and `dp` every cycle;
  - `anode` is all ones, `seg` = 7'b1111111, `dp_n` = 1, and `frame_done` = 0.
- When `enable` rises, the scan starts at digit 0 using the last captured shadow.
- Digit output for shadow digit `idx`:
  - `seg` = hex decode of nibble `idx`, or 7'b1111111 if the digit is blanked;
  - `dp_n` = ~dp[idx], forced to 1 if the digit is blanked;
  - `anode` is low on bit `idx` only, and only when `cnt` >= GUARD_CYCLES.
- A blanked digit keeps its anode high for the whole slot.
- During the guard interval `seg` and `dp_n` already carry the new digit's value, so the segments settle before the anode turns on.
- Hex codes, 0-F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.

## Timing
- Reset values:
  - `anode` = all ones, `seg` = 7'b1111111, `dp_n` = 1, `frame_done` = 0;
  - `cnt` = 0, `idx` = 0, shadow = 0.
- Reset dominates `enable`. Reset asserted mid-frame takes effect on the next edge, with no partial frame_done.
- The first frame after reset shows shadow 0, or whatever was captured while `enable` was low.
- `seg`, `dp_n`, `anode` and `frame_done` are all registered. Output at cycle t+1 reflects `cnt`, `idx` and shadow at cycle t.
- A frame lasts NUM_DIGITS*REFRESH_DIV cycles.
- Input changes made mid-frame become visible only in the frame after the next frame-end capture.
- Counter widths are $clog2 of the range, minimum 1 bit.

## Configuration
- `SEVSEG_LZ_BLANK_EN` defined: leading-zero suppression.
  - Digit i is effectively blanked when every shadow nibble from i up to NUM_DIGITS-1 is zero.
  - Digit 0 is never suppressed.
  - Suppression is ORed with `blank`.
- Not defined: only `blank` controls blanking, and all zero digits are shown.

## Structure
- Package `seven_seg_pkg` holds:
  - the 16-entry hex segment table;
  - `SEG_OFF` = 7'b1111111;
  - the segment-order localparams.
- One combinational sub-module, `seg_hex_decode`: 4-bit nibble in, 7-bit active-low segments out, using the package table.
- Counters, shadow registers, suppression logic and output registers live in `seven_seg_scan`.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
- Reset held for 3 cycles with `enable`=1 -> `anode`=1111, `seg`=1111111, `dp_n`=1 and `frame_done`=0 throughout.
- `value`=16'h12AF, `enable`=1 -> scan sequence, one pair per slot:
  - `anode`=1110 with `seg`=0111000 (F);
  - 1101 with 0001000 (A);
  - 1011 with 0010010 (2);
  - 0111 with 1001111 (1);
  - `anode`=1111 for the first 2 cycles of each slot;
  - `frame_done` pulses every 32 cycles.
- Change `value` from 16'h12AF to 16'h3456 during slot 1 -> the rest of that frame still shows 12AF; the next frame shows 3456.
- `dp`=4'b0100 -> `dp_n`=0 only while `anode`=1011. `blank`=4'b1000 -> `anode` bit 3 is never low.
- `value`=16'h0050:
  - with `SEVSEG_LZ_BLANK_EN`, only digits 1 and 0 light (5, 0);
  - without it, all four digits light (0, 0, 5, 0).
- Drop `enable` during slot 2 -> the next cycle `anode`=1111 and `seg`=1111111. Re-enable -> digit 0 lights after the guard, with no `frame_done` pulse for the aborted frame.
